// File: rtl/debounce_inputs.sv
// debounce_inputs: per-channel synchroniser + debouncer with edge pulses, sticky W1C events and masked irq.
// Optional per-channel rising-edge counters on count_o when DEBOUNCE_EVENT_COUNT_EN is defined.
module debounce_inputs #(
  parameter int                    NUM_INPUTS      = 8,
  parameter int                    SYNC_STAGES     = 2,
  parameter int                    DEBOUNCE_CYCLES = 5_000_000,
  parameter logic [NUM_INPUTS-1:0] RESET_LEVEL     = '0,
  parameter int                    COUNT_WIDTH     = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_INPUTS-1:0]             in_i,
  output logic [NUM_INPUTS-1:0]             level_o,
  output logic [NUM_INPUTS-1:0]             rise_o,
  output logic [NUM_INPUTS-1:0]             fall_o,
  output logic [NUM_INPUTS-1:0]             event_o,
  input  logic [NUM_INPUTS-1:0]             clear_i,
  input  logic [NUM_INPUTS-1:0]             irq_mask_i,
`ifdef DEBOUNCE_EVENT_COUNT_EN
  output logic [NUM_INPUTS*COUNT_WIDTH-1:0] count_o,
`endif
  output logic                              irq_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] MAX = CW'(DEBOUNCE_CYCLES);

  typedef enum logic {IDLE, COUNT} state_e;

  if (NUM_INPUTS < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || COUNT_WIDTH < 1) begin : g_param_check
    $error("debounce_inputs: illegal parameter value");
  end

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d, rise_q, rise_d, fall_q, fall_d, event_q;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync_q  <= {SYNC_STAGES{RESET_LEVEL[i]}};
        state_q <= IDLE;
        cnt_q   <= '0;
        level_q <= RESET_LEVEL[i];
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        event_q <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], in_i[i]};
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        event_q <= (rise_q | fall_q) ? 1'b1 : clear_i[i] ? 1'b0 : event_q;
      end
    end

    // A bounce back to the accepted level abandons the count without an edge.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (state_q == IDLE) begin
        cnt_d = '0;
        if (sync != level_q) begin
          cnt_d   = CW'(1);
          state_d = COUNT;
        end
      end else if (sync == level_q) begin
        cnt_d   = '0;
        state_d = IDLE;
      end else if (cnt_q == MAX) begin
        level_d = sync;
        rise_d  = sync;
        fall_d  = ~sync;
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    assign level_o[i] = level_q;
    assign rise_o[i]  = rise_q;
    assign fall_o[i]  = fall_q;
    assign event_o[i] = event_q;

    a_invariant: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (cnt_q <= MAX) && !(rise_q && fall_q));

`ifdef DEBOUNCE_EVENT_COUNT_EN
    logic [COUNT_WIDTH-1:0] ev_cnt_q;

    // Saturating; a rise coinciding with a clear restarts the count at one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ev_cnt_q <= '0;
      else if (rise_q) ev_cnt_q <= clear_i[i] ? COUNT_WIDTH'(1) : (&ev_cnt_q) ? ev_cnt_q : ev_cnt_q + COUNT_WIDTH'(1);
      else if (clear_i[i]) ev_cnt_q <= '0;
    end

    assign count_o[i*COUNT_WIDTH +: COUNT_WIDTH] = ev_cnt_q;
`endif
  end

  assign irq_o = |(event_o & irq_mask_i);
endmodule
